// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 1024;

    function automatic int gid_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int  NREQ = DEF_NREQ,
    localparam int GW   = gid_width(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [GW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [GW-1:0]   idx,
    output logic            found
);

    logic [GW-1:0] cand_s;

    // Walk the requesters starting at ptr and keep the first one that is valid.
    always_comb begin
        grant  = {NREQ{1'b0}};
        idx    = {GW{1'b0}};
        found  = 1'b0;
        cand_s = {GW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            cand_s = GW'((int'(ptr) + k) % NREQ);
            if (!found && valid[cand_s]) begin
                found         = 1'b1;
                grant[cand_s] = 1'b1;
                idx           = cand_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NREQ requesters into one UART transmitter,
// with packet locking and a timeout on the transmitter's busy handshake.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  NREQ    = DEF_NREQ,
    parameter int  TIMEOUT = DEF_TIMEOUT,
    localparam int GW      = gid_width(NREQ)
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_send,
    output logic [7:0]        tx_dat,
    input  logic              tx_busy,
    output logic [GW-1:0]     grant_id,
    output logic              active,
    output logic              timeout_err
);

    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [GW-1:0] IDX_LAST = GW'(NREQ - 1);

    arb_state_e    state_q, state_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic          lock_q, lock_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tx_send_q, tx_send_d;
    logic [7:0]    tx_dat_q, tx_dat_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic          active_q, active_d;
    logic          timeout_err_q, timeout_err_d;

    logic [NREQ-1:0] owner_s;
    logic [NREQ-1:0] elig_s;
    logic [NREQ-1:0] pick_grant_s;
    logic [GW-1:0]   pick_idx_s;
    logic            pick_found_s;
    logic            accept_s;

    // While a packet is locked only its owner may compete.
    always_comb begin
        owner_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_id_q;
        if (lock_q) begin
            elig_s = req_valid & owner_s;
        end else begin
            elig_s = req_valid;
        end
    end

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .valid (elig_s),
        .ptr   (ptr_q),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Ready is combinational; gating with HRESETn keeps it quiet throughout reset.
    always_comb begin
        accept_s  = 1'b0;
        req_ready = {NREQ{1'b0}};
        if (HRESETn && en && (state_q == IDLE) && pick_found_s) begin
            accept_s  = 1'b1;
            req_ready = pick_grant_s;
        end else begin
            accept_s  = 1'b0;
        end
    end

    // Next-state and next-output logic of the byte FSM.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        lock_d        = lock_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        tx_send_d     = 1'b0;
        tx_dat_d      = tx_dat_q;
        grant_id_d    = grant_id_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!en) begin
                    lock_d = 1'b0;
                end else if (accept_s) begin
                    tx_dat_d   = req_data[{pick_idx_s, 3'b000} +: 8];
                    last_d     = req_last[pick_idx_s];
                    lock_d     = req_last[pick_idx_s] ? lock_q : 1'b1;
                    grant_id_d = pick_idx_s;
                    ptr_d      = (pick_idx_s == IDX_LAST) ? {GW{1'b0}} : pick_idx_s + 1'b1;
                    cnt_d      = {CW{1'b0}};
                    tx_send_d  = 1'b1;
                    state_d    = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (tx_busy) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Transmitter never answered: drop the byte and any packet lock.
                    cnt_d         = {CW{1'b0}};
                    lock_d        = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    tx_send_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    lock_d  = last_q ? 1'b0 : lock_q;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        active_d = (state_d != IDLE);
    end

    // All arbiter state, cleared asynchronously by HRESETn.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= IDLE;
            ptr_q         <= {GW{1'b0}};
            lock_q        <= 1'b0;
            last_q        <= 1'b0;
            cnt_q         <= {CW{1'b0}};
            tx_send_q     <= 1'b0;
            tx_dat_q      <= 8'h00;
            grant_id_q    <= {GW{1'b0}};
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            lock_q        <= lock_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            tx_send_q     <= tx_send_d;
            tx_dat_q      <= tx_dat_d;
            grant_id_q    <= grant_id_d;
            active_q      <= active_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign tx_send     = tx_send_q;
    assign tx_dat      = tx_dat_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter against a byte-level reference model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic        HCLK      = 1'b0;
    logic        HRESETn   = 1'b0;
    logic        en        = 1'b0;
    logic        tx_busy   = 1'b0;
    logic [3:0]  req_valid = 4'h0;
    logic [3:0]  req_last  = 4'hF;
    logic [31:0] req_data  = 32'h0;
    logic [3:0]  req_ready;
    logic        tx_send;
    logic [7:0]  tx_dat;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    always #5 HCLK = ~HCLK;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .en          (en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_send     (tx_send),
        .tx_dat      (tx_dat),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: one byte in flight at a time; phase 0 = no byte,
    // 1 = waiting for the transmitter to go busy, 2 = transmitter busy.
    int         m_phase = 0, m_ptr = 0, m_owner = 0, m_wait = 0, m_win;
    bit         m_lock = 1'b0, m_last = 1'b0, m_err = 1'b0;
    logic [7:0] m_dat = 8'h00;
    int         n_acc = 0;
    int         log_w [4096];
    logic [7:0] log_d [4096];
    logic [3:0] e_rdy;

    function automatic int winner(input logic [3:0] v, input bit lk, input int own, input int p);
        int i;
        for (int k = 0; k < NREQ; k++) begin
            i = (p + k) % NREQ;
            if (v[i] && (!lk || i == own)) return i;
        end
        return -1;
    endfunction

    always_comb m_win = winner(req_valid, m_lock, m_owner, m_ptr);
    assign e_rdy = (HRESETn && m_phase == 0 && en && m_win >= 0) ? 4'(1 << m_win) : 4'd0;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_phase <= 0; m_ptr <= 0; m_owner <= 0; m_wait <= 0;
            m_lock  <= 1'b0; m_last <= 1'b0; m_err <= 1'b0; m_dat <= 8'h00;
        end else begin
            m_err <= 1'b0;
            if (m_phase == 0) begin
                if (!en) m_lock <= 1'b0;
                else if (m_win >= 0) begin
                    m_phase <= 1;
                    m_wait  <= 0;
                    m_owner <= m_win;
                    m_ptr   <= (m_win + 1) % NREQ;
                    m_dat   <= 8'(req_data >> (8 * m_win));
                    m_last  <= req_last[m_win];
                    if (!req_last[m_win]) m_lock <= 1'b1;
                    log_w[n_acc % 4096] <= m_win;
                    log_d[n_acc % 4096] <= 8'(req_data >> (8 * m_win));
                    n_acc <= n_acc + 1;
                end
            end else if (m_phase == 1) begin
                if (tx_busy) m_phase <= 2;
                else if (m_wait + 1 == TMO) begin
                    m_phase <= 0; m_err <= 1'b1; m_lock <= 1'b0;
                end else m_wait <= m_wait + 1;
            end else begin
                if (!tx_busy) begin
                    m_phase <= 0;
                    if (m_last) m_lock <= 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge HCLK) begin
        #2;
        if (cmp_on) begin
            chk("req_ready",   32'(req_ready),   32'(e_rdy));
            chk("tx_send",     32'(tx_send),     32'(m_phase == 1));
            chk("active",      32'(active),      32'(m_phase != 0));
            chk("tx_dat",      32'(tx_dat),      32'(m_dat));
            chk("grant_id",    32'(grant_id),    32'(m_owner));
            chk("timeout_err", 32'(timeout_err), 32'(m_err));
        end
    end

    // Transmitter stand-in: busy rises bm_d cycles after tx_send is seen, stays bm_l cycles.
    bit bm_off = 1'b0, bm_rand = 1'b0;
    int bm_d = 1, bm_l = 2, bm_ph = 0, bm_c = 0;
    initial begin
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                bm_ph = 0; tx_busy = 1'b0;
            end else if (bm_ph == 0) begin
                if (tx_send && !bm_off) begin
                    if (bm_rand) begin
                        bm_d = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
                        bm_l = int'($urandom_range(1, 5));
                    end
                    if (bm_d == 0) begin tx_busy = 1'b1; bm_ph = 2; bm_c = bm_l; end
                    else begin bm_ph = 1; bm_c = bm_d; end
                end
            end else if (bm_ph == 1) begin
                bm_c--;
                if (bm_c == 0) begin tx_busy = 1'b1; bm_ph = 2; bm_c = bm_l; end
            end else begin
                bm_c--;
                if (bm_c == 0) begin tx_busy = 1'b0; bm_ph = 0; end
            end
        end
    end

    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0; en = 1'b0; req_valid = 4'h0; req_last = 4'hF;
        bm_off = 1'b0; bm_rand = 1'b0; bm_d = 1; bm_l = 2;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic wait_acc(input int target, input string nm);
        int t = 0;
        while (n_acc < target && t < 300) begin @(negedge HCLK); t++; end
        chk(nm, 32'(n_acc), 32'(target));
    endtask

    initial begin
        int base, t;
        int e21 [5] = '{0, 1, 2, 3, 0};
        int e22w[4] = '{2, 2, 2, 3};
        logic [7:0] e22d[4] = '{8'hA1, 8'hA2, 8'hA3, 8'h33};

        // Ready must stay low in reset even with requests pending.
        @(negedge HCLK);
        cmp_on = 1'b1;
        en = 1'b1; req_valid = 4'hF;
        #1;
        chk("rdy_in_reset", 32'(req_ready), 32'h0);
        chk("send_in_reset", 32'(tx_send), 32'h0);

        // Four requesters, all last: plain rotation.
        do_reset();
        bm_d = 3; bm_l = 10;
        en = 1'b1; req_valid = 4'hF; req_last = 4'hF; req_data = 32'h44332211;
        base = n_acc;
        wait_acc(base + 5, "rr_five_grants");
        for (int i = 0; i < 5; i++) chk("rr_order", 32'(log_w[(base + i) % 4096]), 32'(e21[i]));

        // Locked three-byte packet from requester 2.
        do_reset();
        en = 1'b1; req_valid = 4'b0100; req_last = 4'b1011; req_data = 32'h33A11100;
        base = n_acc;
        wait_acc(base + 1, "lock_b1");
        req_valid = 4'hF; req_data[23:16] = 8'hA2;
        wait_acc(base + 2, "lock_b2");
        req_data[23:16] = 8'hA3; req_last[2] = 1'b1;
        wait_acc(base + 3, "lock_b3");
        wait_acc(base + 4, "lock_after");
        for (int i = 0; i < 4; i++) begin
            chk("lock_grant", 32'(log_w[(base + i) % 4096]), 32'(e22w[i]));
            chk("lock_data",  32'(log_d[(base + i) % 4096]), 32'(e22d[i]));
        end

        // Transmitter never answers: timeout after 16 SEND cycles, lock released.
        do_reset();
        bm_off = 1'b1;
        en = 1'b1; req_valid = 4'b0010; req_last = 4'b1101; req_data = 32'h0000BB00;
        base = n_acc;
        t = 0;
        while (!tx_send && t < 50) begin @(negedge HCLK); t++; end
        chk("tmo_send_seen", 32'(tx_send), 32'h1);
        req_valid = 4'hF; req_last = 4'hF;
        t = 0;
        while (!timeout_err && t < 40) begin @(negedge HCLK); t++; end
        chk("tmo_latency", 32'(t), 32'd16);
        bm_off = 1'b0;
        wait_acc(base + 2, "tmo_next");
        chk("tmo_next_grant", 32'(log_w[(base + 1) % 4096]), 32'd2);

        // Enable dropped while the transmitter is busy.
        do_reset();
        bm_d = 1; bm_l = 4;
        en = 1'b1; req_valid = 4'hF; req_last = 4'hF;
        base = n_acc;
        wait_acc(base + 1, "en_first");
        t = 0;
        while (!(active && !tx_send) && t < 50) begin @(negedge HCLK); t++; end
        chk("en_wait_done_seen", 32'(active && !tx_send), 32'h1);
        en = 1'b0;
        t = 0;
        while (active && t < 50) begin @(negedge HCLK); t++; end
        chk("en_byte_done", 32'(active), 32'h0);
        repeat (4) @(negedge HCLK);
        chk("en_no_grant", 32'(n_acc - base), 32'd1);
        en = 1'b1;
        wait_acc(base + 2, "en_resume");
        chk("en_ptr_kept", 32'(log_w[(base + 1) % 4096]), 32'd1);

        // Reset in the middle of SEND.
        do_reset();
        bm_off = 1'b1;
        en = 1'b1; req_valid = 4'hF; req_data = 32'h0000005A;
        t = 0;
        while (!tx_send && t < 50) begin @(negedge HCLK); t++; end
        chk("rst_pre_dat", 32'(tx_dat), 32'h5A);
        @(negedge HCLK);
        #3 HRESETn = 1'b0;
        #1;
        chk("rst_send",   32'(tx_send),     32'h0);
        chk("rst_active", 32'(active),      32'h0);
        chk("rst_dat",    32'(tx_dat),      32'h0);
        chk("rst_gid",    32'(grant_id),    32'h0);
        chk("rst_err",    32'(timeout_err), 32'h0);
        chk("rst_rdy",    32'(req_ready),   32'h0);
        repeat (2) @(negedge HCLK);
        bm_off = 1'b0; base = n_acc;
        HRESETn = 1'b1;
        wait_acc(base + 1, "rst_regrant");
        chk("rst_first_winner", 32'(log_w[base % 4096]), 32'd0);

        // Pointer wrap from requester 3 back to 0.
        do_reset();
        en = 1'b1; req_valid = 4'b1000;
        base = n_acc;
        wait_acc(base + 1, "wrap_first");
        req_valid = 4'b1001;
        wait_acc(base + 2, "wrap_second");
        chk("wrap_g3", 32'(log_w[base % 4096]),       32'd3);
        chk("wrap_g0", 32'(log_w[(base + 1) % 4096]), 32'd0);

        // Random traffic against the model.
        do_reset();
        bm_rand = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge HCLK);
            en        = ($urandom_range(0, 15) != 0);
            req_valid = 4'($urandom_range(0, 15));
            req_last  = 4'($urandom) | 4'($urandom);
            req_data  = $urandom;
        end
        @(negedge HCLK);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
        $fatal(1);
    end

endmodule
